// File: rtl/key_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scanner_if
// Description : Matrix I/O and debounced key/press-event bundle for the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_matrix_scanner_if;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] keys;
    logic        press_valid;
    logic [3:0]  press_index;

    modport master (
        input  col_n,
        output row_n,
        output keys,
        output press_valid,
        output press_index
    );

    modport slave (
        output col_n,
        input  row_n,
        input  keys,
        input  press_valid,
        input  press_index
    );
endinterface
`default_nettype wire

// File: rtl/key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scanner
// Description : 4x4 key matrix row scanner with per-key debounce and press events.
// Revision    : 1.0 - initial release
// ============================================================================
module key_matrix_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    key_matrix_scanner_if.master  bus
);
    localparam int              c_dw         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_dw-1:0] c_dwell_last = c_dw'(SCAN_DIV - 1);
    localparam logic [4:0]      c_deb        = 5'(DEBOUNCE_SCANS);

    logic [3:0]      r_col_meta;
    logic [3:0]      r_col_sync;
    logic [1:0]      r_row;
    logic [c_dw-1:0] r_dwell;
    logic [3:0]      r_row_n;
    logic [15:0]     r_keys;
    logic [3:0]      r_cnt [16];
    logic [3:0]      r_pend;
    logic [1:0]      r_pend_row;
    logic            r_press_valid;
    logic [3:0]      r_press_index;

    logic            w_sample;
    logic [3:0]      w_raw;
    logic [3:0]      w_rise;
    logic [1:0]      w_sel;

    always_comb begin
        w_sample = (r_dwell == c_dwell_last);
        w_raw    = ~r_col_sync;
        w_rise   = 4'd0;
        // A key rises when its confirming sample arrives while it is still released.
        for (int c = 0; c < 4; c++) begin
            w_rise[c] = w_sample && w_raw[c] && !r_keys[{r_row, 2'(c)}]
                        && ({1'b0, r_cnt[{r_row, 2'(c)}]} + 5'd1 == c_deb);
        end
    end

    always_comb begin
        w_sel = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (r_pend[c]) begin
                w_sel = 2'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
            r_row      <= 2'd0;
            r_dwell    <= '0;
            r_row_n    <= 4'hF;
        end else begin
            r_col_meta <= bus.col_n;
            r_col_sync <= r_col_meta;
            r_row_n    <= ~(4'b0001 << r_row);
            if (w_sample) begin
                r_dwell <= '0;
                r_row   <= r_row + 2'd1;
            end else begin
                r_dwell <= r_dwell + c_dw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_keys <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_sample && (r_row == i[3:2])) begin
                    if (w_raw[i[1:0]] == r_keys[i]) begin
                        r_cnt[i] <= 4'd0;
                    end else if ({1'b0, r_cnt[i]} + 5'd1 == c_deb) begin
                        r_keys[i] <= w_raw[i[1:0]];
                        r_cnt[i]  <= 4'd0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    // The mask always drains within four cycles, so a new sample finds it empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend        <= 4'd0;
            r_pend_row    <= 2'd0;
            r_press_valid <= 1'b0;
            r_press_index <= 4'd0;
        end else begin
            r_press_valid <= 1'b0;
            if (r_pend != 4'd0) begin
                r_press_valid <= 1'b1;
                r_press_index <= {r_pend_row, w_sel};
                r_pend[w_sel] <= 1'b0;
            end
            if (w_sample) begin
                r_pend     <= w_rise;
                r_pend_row <= r_row;
            end
        end
    end

    assign bus.row_n       = r_row_n;
    assign bus.keys        = r_keys;
    assign bus.press_valid = r_press_valid;
    assign bus.press_index = r_press_index;
endmodule
`default_nettype wire

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Scans the physical 4x4 piano key matrix and produces the debounced 16-bit `keys` vector that piano_system consumes on its `keys` input.
- Drives one active-low row at a time and samples the four active-low column lines.
- Debounces each key independently.
- Emits a one-cycle press event with the key index for each newly pressed key.
- Sits between board I/O and piano_system in the 100 MHz `clk` domain.

Parameters:
- SCAN_DIV, 1000, `clk` cycles each row is driven (dwell); must be >= 8.
- DEBOUNCE_SCANS, 4, consecutive identical samples of a key required before `keys` changes; range 1..15.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- col_n  input  4  matrix column lines; active-low, asynchronous to `clk`, pulled up externally.
- row_n  output  4  matrix row drives; at most one bit low.
- keys  output  16  debounced key state; bit i = key (row*4 + col); 1 = pressed.
- press_valid  output  1  one-cycle pulse per newly pressed key.
- press_index  output  4  index of the key for the current `press_valid`; holds its value otherwise.

Behaviour:
- **Reset (`reset` = 0), immediately and asynchronously:**
  - `row_n` = 4'hF, `keys` = 0, `press_valid` = 0, `press_index` = 0.
  - Row counter, dwell counter, sync flops, all debounce counters and the pending mask cleared.
- **Reset mid-operation:** partial debounce progress and pending events are discarded.
- **Column synchronizer:** 2-flop synchronizer on `col_n`, resetting to 4'hF. Raw pressed sample for column c = ~col_sync[c].
- **Row scan:**
  - Row counter r cycles 0,1,2,3,0,...
  - `row_n` = ~(1 << r), registered.
  - The first rising edge after reset release drives row 0.
  - Dwell counter runs 0..SCAN_DIV-1; on SCAN_DIV-1 it wraps to 0 and r advances (3 wraps to 0).
  - One frame = 4*SCAN_DIV cycles.
- **Sampling:**
  - On the cycle the dwell counter = SCAN_DIV-1, the four synchronized columns are taken as raw samples for keys r*4+0..r*4+3.
  - Settle time for the row drive plus synchronizer delay is guaranteed by SCAN_DIV >= 8.
  - Keys of other rows are not touched that cycle.
- **Debounce, per key i, evaluated only when i's row is sampled:**
  - Raw == `keys[i]`: cnt[i] <= 0.
  - Raw != `keys[i]` and cnt[i] + 1 == DEBOUNCE_SCANS: `keys[i]` <= raw and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i] + 1.
  - Counter width is 4 bits and never overflows.
- **Press detection:**
  - A 0->1 transition of `keys[i]` sets pending bit i in a 4-bit pending mask for the sampled row, in the same cycle `keys` updates.
  - Releases (1->0) generate no event.
- **Event drain:**
  - Starting the cycle after `keys` updates, each cycle with a nonzero mask selects the lowest set bit c.
  - That cycle: `press_valid` = 1, `press_index` = r_sampled*4 + c, then bit c is cleared.
  - Up to 4 events drain in 4 consecutive cycles, which completes before the next row sample (SCAN_DIV >= 8), so the mask never overflows.
  - `press_valid` is registered and never high for two cycles for the same event.
- **Latency:** a clean press is reflected in `keys` at the DEBOUNCE_SCANS-th sample of its row after the press is visible on `col_n` (plus 2 sync cycles); `press_valid` follows 1 cycle later.
- **Ghosting:** the matrix has per-key diodes; there is no anti-ghosting logic, and any combination of keys is reported as sampled.

Test Plan:
Sim parameters SCAN_DIV=8, DEBOUNCE_SCANS=3 (frame = 32 cycles). The bench models the matrix as `col_n[c]` = ~(pressed[row*4+c] & ~`row_n[row]`) for the active row.
- Assert `reset` low mid-run, then release -> while low, `row_n`=F and `keys`=0; after release, `row_n` sequence E,D,B,7 with 8 cycles each, repeating.
- Hold key 0 pressed steadily -> `keys`[0] rises at the 3rd row-0 sample after the press; next cycle `press_valid`=1 for exactly 1 cycle with `press_index`=0; no further pulses while held.
- Key 5 pressed for 2 frames, released 1 frame, pressed 2 frames, released -> `keys`[5] never sets; `press_valid` never asserts.
- Keys 8, 10, 11 pressed in the same cycle -> `keys` bits 8, 10, 11 set on the same sample cycle; `press_valid` high for 3 consecutive cycles with `press_index` 8, 10, 11 in that order.
- Release key 0 after it is set -> `keys`[0] clears at the 3rd released row-0 sample; no `press_valid`.
- Drive `reset` low while key 3's counter is at 2 -> `keys`, `press_valid` and `row_n`(=F) clear immediately; after release, key 3 needs 3 fresh samples to set.
